// File: rtl/regfile_wb_sched.sv
// Writeback scheduler and scoreboard for an 8-entry, 16-bit register file.
// The ALU and the load unit share one registered write port. A busy bitmap
// marks registers that still have a write in flight, so issue can stall on
// RAW and WAW hazards.
// Optional feature macro: WB_MEM_PRIORITY_EN. When it is defined, the load
// unit always wins a tie. When it is undefined, ties alternate round-robin.
module regfile_wb_sched #(
    parameter int unsigned AW = 3,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rd,
    output logic          issue_ready,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          raw_stall,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    output logic          wen,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic [3:0]    pending_cnt
);

    localparam int unsigned NR = 1 << AW;

    logic [NR-1:0] busy_q, busy_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    pending_q, pending_d;
    logic [NR-1:0] set_mask, clr_mask;
    logic          grant;
    logic [AW-1:0] grant_rd;
    logic [DW-1:0] grant_data;

`ifndef WB_MEM_PRIORITY_EN
    // Set when the load unit won the most recent tie.
    logic last_mem_q, last_mem_d;
`endif

    // Scoreboard lookups for issue and decode.
    always_comb begin
        issue_ready = ~busy_q[issue_rd] | (issue_rd == '0);
        raw_stall   = busy_q[rs1] | busy_q[rs2];
    end

    // Arbitration between the two writeback requesters.
    always_comb begin
        alu_ready = alu_valid;
        mem_ready = mem_valid;
`ifdef WB_MEM_PRIORITY_EN
        if (alu_valid && mem_valid) begin
            alu_ready = 1'b0;
        end
`else
        last_mem_d = last_mem_q;
        if (alu_valid && mem_valid) begin
            alu_ready  = last_mem_q;
            mem_ready  = ~last_mem_q;
            last_mem_d = ~last_mem_q;
        end
`endif
        grant      = alu_ready | mem_ready;
        grant_rd   = mem_ready ? mem_rd : alu_rd;
        grant_data = mem_ready ? mem_data : alu_data;
    end

    // Next state for the write stage, the busy bitmap and the pending count.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && issue_ready && issue_rd != '0) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (grant) begin
            clr_mask[grant_rd] = 1'b1;
        end
        // A clear and a set of the same register at one edge leave it busy.
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;

        wen_d   = grant && (grant_rd != '0);
        waddr_d = grant ? grant_rd : waddr_q;
        wdata_d = grant ? grant_data : wdata_q;

        pending_d = '0;
        for (int i = 0; i < NR; i++) begin
            pending_d = pending_d + 4'(busy_d[i]);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
`ifndef WB_MEM_PRIORITY_EN
            last_mem_q <= 1'b1;
`endif
        end else begin
            busy_q    <= busy_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
`ifndef WB_MEM_PRIORITY_EN
            last_mem_q <= last_mem_d;
`endif
        end
    end

    assign wen         = wen_q;
    assign waddr       = waddr_q;
    assign wdata       = wdata_q;
    assign pending_cnt = pending_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched. It runs directed scenarios and then
// random traffic. All of it is checked against a behavioural scoreboard model.
module tb_regfile_wb_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [2:0]  issue_rd = '0;
    logic        issue_ready;
    logic [2:0]  rs1 = '0;
    logic [2:0]  rs2 = '0;
    logic        raw_stall;
    logic        alu_valid = 1'b0;
    logic [2:0]  alu_rd = '0;
    logic [15:0] alu_data = '0;
    logic        alu_ready;
    logic        mem_valid = 1'b0;
    logic [2:0]  mem_rd = '0;
    logic [15:0] mem_data = '0;
    logic        mem_ready;
    logic        wen;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [3:0]  pending_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    bit        m_busy [8];
    bit        m_last_mem;
    bit        m_wen;
    bit [2:0]  m_waddr;
    bit [15:0] m_wdata;

    regfile_wb_sched dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .raw_stall   (raw_stall),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int busy_count();
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic drive(input bit iv, input bit [2:0] ird, input bit [2:0] r1, input bit [2:0] r2,
                         input bit av, input bit [2:0] ard, input bit [15:0] ad,
                         input bit mv, input bit [2:0] mrd, input bit [15:0] md, input bit r);
        issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        rst = r;
    endtask

    // One clock cycle: check same-cycle outputs, advance the model, check registered outputs.
    task automatic step();
        bit ga, gm, e_ir, e_raw, both;
        bit [2:0] g_rd;
        bit [15:0] g_dat;
        e_ir  = (issue_rd == 3'd0) || !m_busy[issue_rd];
        e_raw = m_busy[rs1] || m_busy[rs2];
        both  = alu_valid && mem_valid;
        ga = alu_valid;
        gm = mem_valid;
        if (both) begin
`ifdef WB_MEM_PRIORITY_EN
            ga = 1'b0;
`else
            if (m_last_mem) gm = 1'b0;
            else ga = 1'b0;
`endif
        end
        #2;
        check_eq("issue_ready", issue_ready, e_ir);
        check_eq("raw_stall", raw_stall, e_raw);
        check_eq("alu_ready", alu_ready, ga);
        check_eq("mem_ready", mem_ready, gm);
        @(posedge clk);
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_last_mem = 1'b1;
        end else begin
            if (ga || gm) begin
                g_rd  = gm ? mem_rd : alu_rd;
                g_dat = gm ? mem_data : alu_data;
                m_wen = (g_rd != 3'd0);
                m_waddr = g_rd;
                m_wdata = g_dat;
                m_busy[g_rd] = 1'b0;
            end else begin
                m_wen = 1'b0;
            end
            if (issue_valid && e_ir && issue_rd != 3'd0) m_busy[issue_rd] = 1'b1;
            if (both) m_last_mem = gm;
        end
        #1;
        check_eq("wen", wen, m_wen);
        check_eq("waddr", waddr, m_waddr);
        check_eq("wdata", wdata, m_wdata);
        check_eq("pending_cnt", pending_cnt, busy_count());
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_last_mem = 1'b1; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;

        // Reset
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        step();
        check_eq("rst_wen", wen, 0);
        check_eq("rst_pending", pending_cnt, 0);
        check_eq("rst_wdata", wdata, 0);

        // Issue r3, then RAW on r3
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check_eq("busy3_pending", pending_cnt, 1);
        drive(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 check_eq("raw_r3", raw_stall, 1);
        step();

        // ALU writes r3
        drive(0, 0, 3, 0, 1, 3, 16'hBEEF, 0, 0, 0, 0);
        step();
        check_eq("beef_wen", wen, 1);
        check_eq("beef_waddr", waddr, 3);
        check_eq("beef_wdata", wdata, 16'hBEEF);
        check_eq("beef_raw", raw_stall, 0);
        check_eq("beef_pending", pending_cnt, 0);

        // Tie arbitration over 4 cycles from a fresh reset
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0, 1, 1, 16'(16'h100 + k), 1, 2, 16'(16'h200 + k), 0);
            step();
`ifdef WB_MEM_PRIORITY_EN
            check_eq("tie_waddr", waddr, 2);
`else
            check_eq("tie_waddr", waddr, (k % 2 == 0) ? 1 : 2);
`endif
        end

        // WAW stall on r5, then grant r5 while re-issuing r5
        drive(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 check_eq("waw_r5", issue_ready, 0);
        step();
        drive(1, 5, 5, 0, 0, 0, 0, 1, 5, 16'h5555, 0);
        step();
        check_eq("r5_wen", wen, 1);
        check_eq("r5_waddr", waddr, 5);

        // Write to r0 is accepted but suppressed
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 16'h1234, 0);
        step();
        check_eq("r0_wen", wen, 0);

        // Reset while registers are pending
        drive(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drive(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        check_eq("three_pending", pending_cnt, 3);
        drive(0, 0, 2, 4, 1, 6, 16'hAAAA, 0, 0, 0, 1);
        step();
        check_eq("midrst_pending", pending_cnt, 0);
        check_eq("midrst_wen", wen, 0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 1), 3'($urandom), 3'($urandom), 3'($urandom),
                  $urandom_range(0, 2) != 0, 3'($urandom), 16'($urandom),
                  $urandom_range(0, 2) != 0, 3'($urandom), 16'($urandom),
                  $urandom_range(0, 59) == 0);
            step();
        end
        idle();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
